psum_row_scheduler: RTL and testbench

- Sequences one output-neuron adder slot of the SNN accelerator: collects one partial sum per PE for each output row, fetches the prior membrane potential, accumulates it and applies the threshold.
- Emits membrane write-back and spike events, and steps through rows and timesteps.
- Sits between the PE array and membrane memory / spike output buffer, replacing free-running adder sequencing with an explicit, backpressure-aware controller.

---
 rtl/psum_row_scheduler_if.sv | 43 ++++
 rtl/psum_row_scheduler.sv | 165 ++++++++++++++++
 tb/tb_psum_row_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/psum_row_scheduler_if.sv
// Handshake bundle between the adder-slot scheduler, PE array,
// membrane memory and spike buffer.
interface psum_row_scheduler_if #(
  parameter int NUM_PE   = 5,
  parameter int MP_WIDTH = 13,
  parameter int ROW_W    = 3,
  parameter int SLOT_W   = 3
);
  logic                       start;
  logic [NUM_PE-1:0]          ps_valid;
  logic [NUM_PE*MP_WIDTH-1:0] ps_data;
  logic [NUM_PE-1:0]          ps_ready;
  logic                       mp_rd_req;
  logic [ROW_W-1:0]           mp_rd_addr;
  logic                       mp_rd_valid;
  logic [MP_WIDTH-1:0]        mp_rd_data;
  logic                       mp_wr_valid;
  logic [ROW_W-1:0]           mp_wr_addr;
  logic [MP_WIDTH-1:0]        mp_wr_data;
  logic                       mp_wr_ready;
  logic                       spk_valid;
  logic [ROW_W+SLOT_W-1:0]    spk_addr;
  logic                       spk_ready;
  logic                       busy;
  logic                       step_done;
  logic                       first_step;

  modport master (
    output start, ps_valid, ps_data, mp_rd_valid, mp_rd_data,
    output mp_wr_ready, spk_ready,
    input  ps_ready, mp_rd_req, mp_rd_addr, mp_wr_valid,
    input  mp_wr_addr, mp_wr_data, spk_valid, spk_addr,
    input  busy, step_done, first_step
  );

  modport slave (
    input  start, ps_valid, ps_data, mp_rd_valid, mp_rd_data,
    input  mp_wr_ready, spk_ready,
    output ps_ready, mp_rd_req, mp_rd_addr, mp_wr_valid,
    output mp_wr_addr, mp_wr_data, spk_valid, spk_addr,
    output busy, step_done, first_step
  );
endinterface

// File: rtl/psum_row_scheduler.sv
// Adder-slot row scheduler: collect PE partial sums, accumulate, threshold.
// Define LEAK_EN to subtract LEAK (floored at 0) before the threshold compare.
module psum_row_scheduler #(
  parameter int NUM_PE    = 5,
  parameter int MP_WIDTH  = 13,
  parameter int THRESHOLD = 16,
  parameter int NUM_ROWS  = 5,
  parameter int ROW_W     = 3,
  parameter int ADDER_NUM = 0,
  parameter int SLOT_W    = 3
`ifdef LEAK_EN
  , parameter int LEAK    = 1
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  psum_row_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, FETCH, SUM, WRITE, SPIKE, ADVANCE
  } state_t;

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [NUM_PE-1:0]       bitmap;
  logic [NUM_PE-1:0]       take;
  logic [NUM_PE-1:0]       bitmap_nxt;
  logic [MP_WIDTH-1:0]     psum [NUM_PE];
  logic [MP_WIDTH-1:0]     prior;
  logic [MP_WIDTH-1:0]     acc;
  logic [MP_WIDTH-1:0]     lk;
  logic [MP_WIDTH-1:0]     mp_nxt;
  logic                    spike_nxt;
  logic                    spike;
  logic                    first_step;
  logic                    rd_req;
  logic                    wr_valid;
  logic [MP_WIDTH-1:0]     wr_data;
  logic                    spk_valid;
  logic [ROW_W+SLOT_W-1:0] spk_addr;
  logic                    step_done;

  always_comb begin
    take       = bus.ps_valid & ~bitmap;
    bitmap_nxt = bitmap | take;
  end

  // Sum wraps modulo 2^MP_WIDTH by construction of acc's width
  always_comb begin
    acc = prior;
    for (int i = 0; i < NUM_PE; i++) begin
      acc = acc + psum[i];
    end
  end

  always_comb begin
`ifdef LEAK_EN
    lk = (acc > MP_WIDTH'(LEAK)) ? acc - MP_WIDTH'(LEAK) : '0;
`else
    lk = acc;
`endif
    spike_nxt = (32'(lk) >= THRESHOLD);
    mp_nxt    = spike_nxt ? lk - MP_WIDTH'(THRESHOLD) : lk;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      bitmap     <= '0;
      prior      <= '0;
      spike      <= 1'b0;
      first_step <= 1'b1;
      rd_req     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
      spk_valid  <= 1'b0;
      spk_addr   <= '0;
      step_done  <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        psum[i] <= '0;
      end
    end else begin
      rd_req    <= 1'b0;
      step_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) state <= COLLECT;
        end
        COLLECT: begin
          for (int i = 0; i < NUM_PE; i++) begin
            if (take[i]) psum[i] <= bus.ps_data[i*MP_WIDTH +: MP_WIDTH];
          end
          bitmap <= bitmap_nxt;
          if (&bitmap_nxt) begin
            if (first_step) begin
              prior <= '0;
              state <= SUM;
            end else begin
              rd_req <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.mp_rd_valid) begin
            prior <= bus.mp_rd_data;
            state <= SUM;
          end
        end
        SUM: begin
          wr_data  <= mp_nxt;
          spike    <= spike_nxt;
          wr_valid <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          if (bus.mp_wr_ready) begin
            wr_valid <= 1'b0;
            if (spike) begin
              spk_valid <= 1'b1;
              spk_addr  <= {row, SLOT_W'(ADDER_NUM)};
              state     <= SPIKE;
            end else begin
              state <= ADVANCE;
            end
          end
        end
        SPIKE: begin
          if (bus.spk_ready) begin
            spk_valid <= 1'b0;
            state     <= ADVANCE;
          end
        end
        ADVANCE: begin
          bitmap <= '0;
          if (row < ROW_W'(NUM_ROWS - 1)) begin
            row   <= row + 1'b1;
            state <= COLLECT;
          end else begin
            row        <= '0;
            first_step <= 1'b0;
            step_done  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ps_ready    = (state == COLLECT) ? ~bitmap : '0;
  assign bus.mp_rd_req   = rd_req;
  assign bus.mp_rd_addr  = row;
  assign bus.mp_wr_valid = wr_valid;
  assign bus.mp_wr_addr  = row;
  assign bus.mp_wr_data  = wr_data;
  assign bus.spk_valid   = spk_valid;
  assign bus.spk_addr    = spk_addr;
  assign bus.busy        = (state != IDLE);
  assign bus.step_done   = step_done;
  assign bus.first_step  = first_step;

endmodule

// File: tb/tb_psum_row_scheduler.sv
// Directed table-driven bench for psum_row_scheduler.
// Expected values hand-computed with THRESHOLD=16, ADDER_NUM=0.
module tb_psum_row_scheduler;
  localparam int NPE = 5;
  localparam int W   = 13;
  localparam int RW  = 3;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_row_scheduler_if #(
    .NUM_PE(NPE), .MP_WIDTH(W), .ROW_W(RW), .SLOT_W(SW)
  ) bus ();

  psum_row_scheduler #(
    .NUM_PE(NPE), .MP_WIDTH(W), .THRESHOLD(16), .NUM_ROWS(5),
    .ROW_W(RW), .ADDER_NUM(0), .SLOT_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int ps [NPE];
    int rd;
    int dat;
    int spk;
    int ldat;
    int lspk;
    int bp;
  } vec_t;

  vec_t vec [11];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int p0, input int p1,
                         input int p2, input int p3, input int p4,
                         input int rd, input int dat, input int spk,
                         input int ldat, input int lspk, input int bp);
    vec[i].ps[0] = p0; vec[i].ps[1] = p1; vec[i].ps[2] = p2;
    vec[i].ps[3] = p3; vec[i].ps[4] = p4;
    vec[i].rd = rd; vec[i].dat = dat; vec[i].spk = spk;
    vec[i].ldat = ldat; vec[i].lspk = lspk; vec[i].bp = bp;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Feeds PE4 down to PE0, one per cycle; dup replays PE2 while PE1 goes in
  task automatic feed(input int ps [NPE], input int dup);
    for (int k = NPE - 1; k >= 0; k--) begin
      int t;
      t = 0;
      while (!bus.ps_ready[k] && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("ps_ready_wait", int'(bus.ps_ready[k]), 1);
      bus.ps_valid = '0;
      bus.ps_valid[k] = 1'b1;
      bus.ps_data[k*W +: W] = W'(ps[k]);
      if (dup != 0 && k == 1) begin
        chk("dup_ready_pe2", int'(bus.ps_ready[2]), 0);
        bus.ps_valid[2] = 1'b1;
        bus.ps_data[2*W +: W] = 13'd100;
      end
      @(negedge clk);
    end
    bus.ps_valid = '0;
  endtask

  task automatic do_fetch(input int row, input int rd);
    chk("rd_req", int'(bus.mp_rd_req), 1);
    chk("rd_addr", int'(bus.mp_rd_addr), row);
    @(negedge clk);
    chk("rd_req_pulse", int'(bus.mp_rd_req), 0);
    bus.mp_rd_valid = 1'b1;
    bus.mp_rd_data = W'(rd);
    @(negedge clk);
    bus.mp_rd_valid = 1'b0;
  endtask

  task automatic wait_wr(output int lat);
    lat = 0;
    while (!bus.mp_wr_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_valid", int'(bus.mp_wr_valid), 1);
  endtask

  task automatic run_row(input vec_t v, input int row, input int fetch);
    int lat;
    int ed;
    int es;
`ifdef LEAK_EN
    ed = v.ldat; es = v.lspk;
`else
    ed = v.dat; es = v.spk;
`endif
    feed(v.ps, v.bp);
    if (fetch != 0) begin
      do_fetch(row, v.rd);
      wait_wr(lat);
      chk("wr_latency_fetch", lat + 3, 4);
    end else begin
      chk("no_rd_req", int'(bus.mp_rd_req), 0);
      wait_wr(lat);
      chk("wr_latency_first", lat + 1, 2);
    end
    chk("wr_addr", int'(bus.mp_wr_addr), row);
    chk("wr_data", int'(bus.mp_wr_data), ed);
    if (v.bp != 0) begin
      repeat (3) begin
        @(negedge clk);
        chk("bp_wr_valid", int'(bus.mp_wr_valid), 1);
        chk("bp_wr_data", int'(bus.mp_wr_data), ed);
      end
    end
    bus.mp_wr_ready = 1'b1;
    @(negedge clk);
    bus.mp_wr_ready = 1'b0;
    chk("wr_drop", int'(bus.mp_wr_valid), 0);
    if (es != 0) begin
      chk("spk_valid", int'(bus.spk_valid), 1);
      chk("spk_addr", int'(bus.spk_addr), row * 8);
      bus.spk_ready = 1'b1;
      @(negedge clk);
      bus.spk_ready = 1'b0;
      chk("spk_drop", int'(bus.spk_valid), 0);
    end else begin
      chk("no_spk", int'(bus.spk_valid), 0);
    end
  endtask

  task automatic check_step_end();
    int sd;
    sd = 0;
    repeat (6) begin
      if (bus.step_done) sd++;
      @(negedge clk);
    end
    chk("step_done_count", sd, 1);
    chk("idle_busy", int'(bus.busy), 0);
    chk("first_step_clear", int'(bus.first_step), 0);
  endtask

  initial begin
    int lat;
    //       idx p0  p1 p2 p3 p4 rd    dat spk ldat lspk bp
    set_vec(0,  1,  2, 5, 4, 3, 0,    15, 0,  14,  0,  0);
    set_vec(1,  5,  5, 5, 5, 0, 0,    4,  1,  3,   1,  0);
    set_vec(2,  0,  0, 0, 0, 0, 0,    0,  0,  0,   0,  0);
    set_vec(3,  16, 0, 0, 0, 0, 0,    0,  1,  15,  0,  0);
    set_vec(4,  3,  0, 0, 0, 0, 0,    3,  0,  2,   0,  0);
    set_vec(5,  1,  0, 0, 0, 0, 15,   0,  1,  15,  0,  0);
    set_vec(6,  1,  1, 1, 1, 1, 8190, 3,  0,  2,   0,  0);
    set_vec(7,  2,  2, 2, 2, 2, 4,    14, 0,  13,  0,  1);
    set_vec(8,  0,  0, 0, 3, 0, 10,   13, 0,  12,  0,  0);
    set_vec(9,  0,  0, 0, 0, 0, 20,   4,  1,  3,   1,  0);
    set_vec(10, 1,  1, 1, 1, 1, 0,    5,  0,  4,   0,  0);

    bus.start = 1'b0;
    bus.ps_valid = '0;
    bus.ps_data = '0;
    bus.mp_rd_valid = 1'b0;
    bus.mp_rd_data = '0;
    bus.mp_wr_ready = 1'b0;
    bus.spk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_first_step", int'(bus.first_step), 1);
    chk("rst_ps_ready", int'(bus.ps_ready), 0);
    chk("rst_wr_valid", int'(bus.mp_wr_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 0) pulse_start();
      run_row(vec[i], i % 5, (i >= 5) ? 1 : 0);
      if (i % 5 == 4) check_step_end();
    end

    // Reset while a write is pending
    pulse_start();
    feed(vec[2].ps, 0);
    do_fetch(0, 1);
    wait_wr(lat);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_wr_valid", int'(bus.mp_wr_valid), 0);
    chk("mid_rst_spk_valid", int'(bus.spk_valid), 0);
    chk("mid_rst_rd_req", int'(bus.mp_rd_req), 0);
    chk("mid_rst_ps_ready", int'(bus.ps_ready), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_step_done", int'(bus.step_done), 0);
    chk("mid_rst_first_step", int'(bus.first_step), 1);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    run_row(vec[10], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
